// File: rtl/redmule_engine_sequencer.sv
// Control FSM that walks the RedMulE engine through one output tile:
// job accept -> X load -> H weight beats per K-chunk -> pipeline drain,
// repeated per chunk, then the finished tile is offered on z_valid/z_ready.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are
// high at the rising edge; valid never depends on ready. clear_i wins over
// any transfer in the same cycle, so x_ready_o/w_ready_o drop while it is
// asserted and the producer never sees a beat accepted that is then lost.
module redmule_engine_sequencer #(
    parameter int unsigned Height      = 4,
    parameter int unsigned Width       = 8,
    parameter int unsigned NumPipeRegs = 3,
    parameter int unsigned DrainCycles = Height * (NumPipeRegs + 1),
    parameter int unsigned KW          = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         start_ready_o,
    input  logic [$clog2(Width+1)-1:0]   cfg_rows_i,
    input  logic [KW-1:0]                cfg_k_chunks_i,
    input  logic                         clear_i,
    input  logic                         x_valid_i,
    output logic                         x_ready_o,
    input  logic                         w_valid_i,
    output logic                         w_ready_o,
    output logic                         in_valid_o,
    output logic                         reg_enable_o,
    output logic                         flush_o,
    output logic                         accumulate_o,
    output logic [Width-1:0]             row_clk_gate_en_o,
    output logic                         z_valid_o,
    input  logic                         z_ready_i,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         busy_o
);

    localparam int unsigned RW = $clog2(Width + 1);
    localparam int unsigned BW = (Height > 1) ? $clog2(Height) : 1;
    localparam int unsigned DW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_X = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    chunk_q, chunk_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             acc_q, acc_d;
    logic [Width-1:0] gate_q, gate_d;
    logic             z_valid_q, z_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             cfg_ok;
    logic             abort;
    logic [Width-1:0] row_mask;

    // A job is legal only with 1..Width rows and at least one K-chunk.
    assign cfg_ok = (cfg_rows_i != '0) && (cfg_rows_i <= RW'(Width)) &&
                    (cfg_k_chunks_i != '0);

    // clear_i only acts outside IDLE.
    assign abort = clear_i && (state_q != S_IDLE);

    // Thermometer mask of the requested rows; latched into the gate register.
    always_comb begin
        row_mask = '0;
        for (int i = 0; i < int'(Width); i++) begin
            row_mask[i] = (i < int'(cfg_rows_i));
        end
    end

    // Next-state and counter logic; abort overrides every state action.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        chunk_d   = chunk_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        acc_d     = acc_q;
        gate_d    = gate_q;
        z_valid_d = z_valid_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (abort) begin
            state_d   = S_IDLE;
            k_d       = '0;
            chunk_d   = '0;
            beat_d    = '0;
            drain_d   = '0;
            acc_d     = 1'b0;
            gate_d    = '0;
            z_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            k_d     = cfg_k_chunks_i;
                            chunk_d = '0;
                            acc_d   = 1'b0;
                            gate_d  = row_mask;
                            state_d = S_LOAD_X;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (x_valid_i) begin
                        beat_d  = '0;
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Gaps in w_valid_i simply hold the beat counter.
                    if (w_valid_i) begin
                        if (beat_q == BW'(Height - 1)) begin
                            beat_d  = '0;
                            drain_d = DW'(DrainCycles - 1);
                            state_d = S_DRAIN;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        // Compare against k-1 so k = 2^KW-1 never wraps.
                        if (chunk_q == (k_q - KW'(1))) begin
                            z_valid_d = 1'b1;
                            state_d   = S_OUT;
                        end else begin
                            chunk_d = chunk_q + KW'(1);
                            acc_d   = 1'b1;
                            state_d = S_LOAD_X;
                        end
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                S_OUT: begin
                    if (z_ready_i) begin
                        z_valid_d = 1'b0;
                        done_d    = 1'b1;
                        acc_d     = 1'b0;
                        gate_d    = '0;
                        chunk_d   = '0;
                        k_d       = '0;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            chunk_q   <= '0;
            beat_q    <= '0;
            drain_q   <= '0;
            acc_q     <= 1'b0;
            gate_q    <= '0;
            z_valid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            chunk_q   <= chunk_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            acc_q     <= acc_d;
            gate_q    <= gate_d;
            z_valid_q <= z_valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Engine and handshake controls decoded from the current state.
    assign start_ready_o     = (state_q == S_IDLE);
    assign busy_o            = (state_q != S_IDLE);
    assign x_ready_o         = (state_q == S_LOAD_X) && !clear_i;
    assign w_ready_o         = (state_q == S_STREAM) && !clear_i;
    assign in_valid_o        = w_valid_i && w_ready_o;
    assign reg_enable_o      = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign flush_o           = abort;
    assign accumulate_o      = acc_q;
    assign row_clk_gate_en_o = gate_q;
    assign z_valid_o         = z_valid_q;
    assign done_o            = done_q;
    assign err_o             = err_q;

endmodule
